// File: rtl/in_intf_stim_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : in_intf_stim_driver_if
// Description : Bundle of the proxy-side transaction port and the DUT-side
//               valid/ready operand port of the in_intf stimulus driver.
//               master = driver side, slave = the proxy / DUT side.
// Revision    : 1.0 - initial release
// ============================================================================
interface in_intf_stim_driver_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DELAY_WIDTH = 4
);
    // Proxy side
    logic                   txn_valid;
    logic                   txn_ready;
    logic [DATA_WIDTH-1:0]  txn_a;
    logic [DATA_WIDTH-1:0]  txn_b;
    logic [DELAY_WIDTH-1:0] txn_delay;
    // DUT side
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_a;
    logic [DATA_WIDTH-1:0]  in_b;
    // Status
    logic                   busy;
    logic [15:0]            sent_count;

    modport master (
        input  txn_valid, txn_a, txn_b, txn_delay, in_ready,
        output txn_ready, in_valid, in_a, in_b, busy, sent_count
    );

    modport slave (
        output txn_valid, txn_a, txn_b, txn_delay, in_ready,
        input  txn_ready, in_valid, in_a, in_b, busy, sent_count
    );
endinterface
`default_nettype wire

// File: rtl/in_intf_stim_driver.sv
`default_nettype none
// ============================================================================
// Module      : in_intf_stim_driver
// Description : Transmit-side transactor for the adder input interface.
//               Buffers {a, b, delay} transactions in a small FIFO, inserts
//               the requested idle cycles, then drives each one onto the
//               DUT port with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module in_intf_stim_driver #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int DELAY_WIDTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    in_intf_stim_driver_if.master   bus
);

    localparam int                 c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]      c_DEPTH    = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW-1:0]    c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW:0]      c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [DELAY_WIDTH-1:0] c_DLY_ONE = DELAY_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0]  r_mem_a [DEPTH];
    logic [DATA_WIDTH-1:0]  r_mem_b [DEPTH];
    logic [DELAY_WIDTH-1:0] r_mem_d [DEPTH];
    logic [c_AW-1:0]        r_wptr;
    logic [c_AW-1:0]        r_rptr;
    logic [c_AW:0]          r_count;

    // FSM and output datapath
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DELAY_WIDTH-1:0] r_dly;
    logic [DATA_WIDTH-1:0]  r_in_a;
    logic [DATA_WIDTH-1:0]  r_in_b;
    logic [15:0]            r_sent;

    logic                   w_txn_ready;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_not_empty;
    logic [DELAY_WIDTH-1:0] w_head_d;

    // No write-through: a full FIFO refuses even when a pop happens this cycle.
    assign w_txn_ready = (r_count < c_DEPTH) && !rst;
    assign w_push      = bus.txn_valid && w_txn_ready;
    assign w_not_empty = (r_count != '0);
    assign w_head_d    = r_mem_d[r_rptr];

    // FIFO storage write; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wptr] <= bus.txn_a;
            r_mem_b[r_wptr] <= bus.txn_b;
            r_mem_d[r_wptr] <= bus.txn_delay;
        end
    end

    // FIFO pointers (wrap naturally at power-of-two depth) and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and pop decision; in_ready only matters in DRIVE.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = (w_head_d == '0) ? S_DRIVE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_dly == c_DLY_ONE) w_state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                if (bus.in_ready) begin
                    if (w_not_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = (w_head_d == '0) ? S_DRIVE : S_WAIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand/delay load on pop, delay countdown in WAIT, transfer counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_a <= '0;
            r_in_b <= '0;
            r_dly  <= '0;
            r_sent <= '0;
        end else begin
            if (w_pop) begin
                r_in_a <= r_mem_a[r_rptr];
                r_in_b <= r_mem_b[r_rptr];
                r_dly  <= w_head_d;
            end else if (r_state == S_WAIT) begin
                r_dly  <= r_dly - c_DLY_ONE;
            end
            if ((r_state == S_DRIVE) && bus.in_ready) begin
                r_sent <= r_sent + 16'd1;
            end
        end
    end

    // Outputs are decoded only from registered state.
    assign bus.txn_ready  = w_txn_ready;
    assign bus.in_valid   = (r_state == S_DRIVE);
    assign bus.in_a       = r_in_a;
    assign bus.in_b       = r_in_b;
    assign bus.busy       = (r_state != S_IDLE) || w_not_empty;
    assign bus.sent_count = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_in_intf_stim_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_in_intf_stim_driver
// Description : Directed self-checking bench for in_intf_stim_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_in_intf_stim_driver;

    localparam int DW = 8;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    in_intf_stim_driver_if #(.DATA_WIDTH(DW), .DELAY_WIDTH(LW)) intf ();

    in_intf_stim_driver #(
        .DATA_WIDTH (DW),
        .DEPTH      (4),
        .DELAY_WIDTH(LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.master)
    );

    // Advance past the next rising edge; sampling happens 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one transaction for exactly one edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] d);
        intf.txn_valid = 1'b1;
        intf.txn_a     = a;
        intf.txn_b     = b;
        intf.txn_delay = d;
        tick();
        intf.txn_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if (intf.in_valid !== 1'b0) $display("FAIL reset_in_valid got=%b exp=0", intf.in_valid); else n_pass++;
        n_total++;
        if (intf.in_a !== 8'h00 || intf.in_b !== 8'h00)
            $display("FAIL reset_data got=%h/%h exp=00/00", intf.in_a, intf.in_b); else n_pass++;
        n_total++;
        if (intf.sent_count !== 16'h0000) $display("FAIL reset_sent got=%h exp=0000", intf.sent_count); else n_pass++;
        n_total++;
        if (intf.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", intf.busy); else n_pass++;
        n_total++;
        if (intf.txn_ready !== 1'b0) $display("FAIL reset_txn_ready got=%b exp=0", intf.txn_ready); else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_total++;
        if (intf.txn_ready !== 1'b1) $display("FAIL post_reset_txn_ready got=%b exp=1", intf.txn_ready); else n_pass++;
    endtask

    task automatic test_single();
        intf.in_ready = 1'b1;
        push(8'h12, 8'h34, 4'd0);               // edge E
        n_total++;
        if (intf.in_valid !== 1'b0) $display("FAIL single_early got=%b exp=0", intf.in_valid); else n_pass++;
        tick();                                  // edge E+1
        n_total++;
        if (intf.in_valid !== 1'b1 || intf.in_a !== 8'h12 || intf.in_b !== 8'h34)
            $display("FAIL single_drive got=%b %h/%h exp=1 12/34", intf.in_valid, intf.in_a, intf.in_b);
        else n_pass++;
        tick();                                  // edge E+2: transfer
        n_total++;
        if (intf.in_valid !== 1'b0 || intf.sent_count !== 16'd1 || intf.busy !== 1'b0)
            $display("FAIL single_done got=%b sent=%0d busy=%b exp=0 1 0", intf.in_valid, intf.sent_count, intf.busy);
        else n_pass++;
    endtask

    task automatic test_delay();
        logic low_ok;
        intf.in_ready = 1'b1;
        push(8'h55, 8'h66, 4'd3);               // edge E
        low_ok = (intf.in_valid === 1'b0);
        for (int k = 0; k < 3; k++) begin        // after E+1..E+3
            tick();
            if (intf.in_valid !== 1'b0) low_ok = 1'b0;
            if (k == 0) begin
                n_total++;
                if (intf.busy !== 1'b1) $display("FAIL delay_busy got=%b exp=1", intf.busy); else n_pass++;
            end
        end
        n_total++;
        if (!low_ok) $display("FAIL delay_idle got=valid_seen exp=3_idle_cycles"); else n_pass++;
        tick();                                  // edge E+4
        n_total++;
        if (intf.in_valid !== 1'b1 || intf.in_a !== 8'h55 || intf.in_b !== 8'h66)
            $display("FAIL delay_drive got=%b %h/%h exp=1 55/66", intf.in_valid, intf.in_a, intf.in_b);
        else n_pass++;
        tick();
        n_total++;
        if (intf.in_valid !== 1'b0 || intf.sent_count !== 16'd2)
            $display("FAIL delay_done got=%b sent=%0d exp=0 2", intf.in_valid, intf.sent_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic hold_ok;
        intf.in_ready = 1'b0;
        push(8'h01, 8'h02, 4'd0);
        push(8'h03, 8'h04, 4'd0);
        hold_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (intf.in_valid !== 1'b1 || intf.in_a !== 8'h01 || intf.in_b !== 8'h02) hold_ok = 1'b0;
            tick();
        end
        n_total++;
        if (!hold_ok) $display("FAIL bp_hold got=%b %h/%h exp=1 01/02", intf.in_valid, intf.in_a, intf.in_b); else n_pass++;
        n_total++;
        if (intf.sent_count !== 16'd2) $display("FAIL bp_no_xfer got=%0d exp=2", intf.sent_count); else n_pass++;
        intf.in_ready = 1'b1;
        tick();
        n_total++;
        if (intf.in_valid !== 1'b1 || intf.in_a !== 8'h03 || intf.in_b !== 8'h04 || intf.sent_count !== 16'd3)
            $display("FAIL bp_second got=%b %h/%h sent=%0d exp=1 03/04 3", intf.in_valid, intf.in_a, intf.in_b, intf.sent_count);
        else n_pass++;
        tick();
        n_total++;
        if (intf.in_valid !== 1'b0 || intf.sent_count !== 16'd4)
            $display("FAIL bp_done got=%b sent=%0d exp=0 4", intf.in_valid, intf.sent_count);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic [7:0] got_a [$];
        logic [7:0] got_b [$];
        logic [7:0] exp_a [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        logic [7:0] exp_b [5] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        intf.in_ready = 1'b0;
        push(8'h10, 8'h20, 4'd0);
        tick();                                  // first entry now parked in DRIVE
        n_total++;
        if (intf.in_valid !== 1'b1) $display("FAIL full_parked got=%b exp=1", intf.in_valid); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            intf.txn_valid = 1'b1;
            intf.txn_a     = 8'h11 + 8'(i);
            intf.txn_b     = 8'h21 + 8'(i);
            intf.txn_delay = 4'd0;
            #1;
            n_total++;
            if (intf.txn_ready !== (i < 4))
                $display("FAIL full_ready_%0d got=%b exp=%b", i, intf.txn_ready, (i < 4));
            else n_pass++;
            tick();
        end
        intf.txn_valid = 1'b0;
        intf.in_ready  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (intf.in_valid === 1'b1) begin
                got_a.push_back(intf.in_a);
                got_b.push_back(intf.in_b);
            end
            tick();
        end
        n_total++;
        if (got_a.size() != 5) $display("FAIL full_count got=%0d exp=5", got_a.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i < got_a.size()) begin
                n_total++;
                if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i])
                    $display("FAIL full_order_%0d got=%h/%h exp=%h/%h", i, got_a[i], got_b[i], exp_a[i], exp_b[i]);
                else n_pass++;
            end
        end
        n_total++;
        if (intf.sent_count !== 16'd9 || intf.busy !== 1'b0)
            $display("FAIL full_done got sent=%0d busy=%b exp=9 0", intf.sent_count, intf.busy);
        else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        logic quiet_ok;
        intf.in_ready = 1'b1;
        #1;
        force dut.r_sent = 16'hFFFF;
        #1;
        release dut.r_sent;
        push(8'h77, 8'h88, 4'd0);
        tick();
        tick();
        n_total++;
        if (intf.sent_count !== 16'h0000) $display("FAIL wrap got=%h exp=0000", intf.sent_count); else n_pass++;

        intf.in_ready = 1'b0;
        push(8'hA1, 8'hB1, 4'd0);
        push(8'hA2, 8'hB2, 4'd0);
        push(8'hA3, 8'hB3, 4'd0);
        n_total++;
        if (intf.in_valid !== 1'b1 || intf.busy !== 1'b1)
            $display("FAIL pre_reset got=%b busy=%b exp=1 1", intf.in_valid, intf.busy);
        else n_pass++;
        #2;
        rst = 1'b1;                              // between edges
        #1;
        n_total++;
        if (intf.in_valid !== 1'b0 || intf.busy !== 1'b0 || intf.txn_ready !== 1'b0)
            $display("FAIL async_reset got=%b busy=%b rdy=%b exp=0 0 0", intf.in_valid, intf.busy, intf.txn_ready);
        else n_pass++;
        n_total++;
        if (intf.in_a !== 8'h00 || intf.sent_count !== 16'h0000)
            $display("FAIL async_reset_data got=%h sent=%h exp=00 0000", intf.in_a, intf.sent_count);
        else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        intf.in_ready = 1'b1;
        quiet_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (intf.in_valid !== 1'b0 || intf.sent_count !== 16'h0000) quiet_ok = 1'b0;
        end
        n_total++;
        if (!quiet_ok) $display("FAIL post_reset_quiet got=%b sent=%0d exp=0 0", intf.in_valid, intf.sent_count); else n_pass++;
        push(8'h99, 8'hAA, 4'd0);
        tick();
        n_total++;
        if (intf.in_valid !== 1'b1 || intf.in_a !== 8'h99 || intf.in_b !== 8'hAA)
            $display("FAIL post_reset_drive got=%b %h/%h exp=1 99/AA", intf.in_valid, intf.in_a, intf.in_b);
        else n_pass++;
        tick();
        n_total++;
        if (intf.sent_count !== 16'd1) $display("FAIL post_reset_sent got=%0d exp=1", intf.sent_count); else n_pass++;
    endtask

    initial begin
        intf.txn_valid = 1'b0;
        intf.txn_a     = '0;
        intf.txn_b     = '0;
        intf.txn_delay = '0;
        intf.in_ready  = 1'b0;
        #3;
        test_reset();
        test_single();
        test_delay();
        test_backpressure();
        test_fifo_full();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/in_intf_stim_driver.md
# in_intf_stim_driver

Synthesizable transmit-side transactor for the adder input interface (`in_intf`), the counterpart of the output-side collection path. It buffers operand transactions from the HVL proxy in a small FIFO, inserts a per-transaction idle delay, and drives them onto the DUT input port with a valid/ready handshake. It lives in the `in_intf_pkg` HDL side and must be emulation-friendly (Veloce): fully synchronous datapath, no delays, no dynamic types.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of each operand `a` and `b`
- `DEPTH`, 4, FIFO entries; power of two, at least 2
- `DELAY_WIDTH`, 4, width of the per-transaction idle-cycle count

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `txn_valid`  in  1  proxy offers a transaction
- `txn_ready`  out  1  FIFO can accept; push occurs on `txn_valid && txn_ready`
- `txn_a`  in  DATA_WIDTH  operand a
- `txn_b`  in  DATA_WIDTH  operand b
- `txn_delay`  in  DELAY_WIDTH  idle cycles to insert before driving this transaction
- `in_valid`  out  1  DUT-side valid
- `in_ready`  in  1  DUT-side ready; transfer on `in_valid && in_ready`
- `in_a`  out  DATA_WIDTH  operand a to DUT
- `in_b`  out  DATA_WIDTH  operand b to DUT
- `busy`  out  1  FIFO non-empty or FSM not IDLE
- `sent_count`  out  16  count of completed DUT-side transfers

## Operation
- FIFO: `DEPTH` entries of {a, b, delay}, circular read/write pointers plus an occupancy counter of width log2(DEPTH)+1.
- `txn_ready` = (count < DEPTH) && !rst. There is no write-through when full: a full FIFO refuses a push even in a cycle with a pop.
- Simultaneous push and pop leave the count unchanged. Pointers wrap modulo `DEPTH`.
- FSM states are IDLE, WAIT, and DRIVE:
  - IDLE: if the FIFO is non-empty, pop and load `in_a`/`in_b`/delay counter. If delay == 0, go to DRIVE; otherwise go to WAIT with counter = delay.
  - WAIT: `in_valid` = 0. Decrement the counter each cycle. When the counter equals 1, go to DRIVE, so exactly `delay` idle cycles are inserted.
  - DRIVE: `in_valid` = 1. On `in_ready`, the transfer completes and `sent_count` increments. Then:
    - FIFO non-empty: pop in the same edge. If the popped delay == 0, stay in DRIVE with new data (back-to-back, `in_valid` stays 1). Otherwise go to WAIT.
    - FIFO empty: go to IDLE and drop `in_valid`.
- Protocol rule: `in_a`/`in_b` hold stable while `in_valid && !in_ready`. `in_valid` never deasserts without a transfer.
- `in_a`/`in_b` retain their last value in IDLE and WAIT; they are not cleared.
- `sent_count` wraps from 0xFFFF to 0x0000.
- `busy` = (state != IDLE) || (count != 0). It is registered-equivalent: derive it from registered state only.

## Timing
- Reset values: `in_valid` 0, `in_a` 0, `in_b` 0, `sent_count` 0, `busy` 0, `txn_ready` 0 while `rst` is high. FSM resets to IDLE, FIFO to empty.
- Reset mid-operation: outputs go to reset values asynchronously, pending FIFO entries are discarded, and an in-flight transfer is abandoned.
- All outputs except `txn_ready` are registered.
- Latency with the FSM in IDLE and the FIFO empty, push at edge E:
  - delay 0: `in_valid` high after edge E+1.
  - delay D: `in_valid` high after edge E+1+D.
- Throughput is one transfer per clock when all delays are 0, the FIFO stays non-empty, and `in_ready` is held high.
- `in_ready` is sampled only in DRIVE. Its value in other states is ignored.

## Test plan
- Single transaction: push a=0x12, b=0x34, delay 0 with `in_ready`=1. Required: `in_valid` high for exactly 1 cycle, 2 edges after the push, carrying 0x12/0x34; `sent_count`=1; `busy` returns to 0.
- Delay insertion: push delay=3 into an idle block. Required: `in_valid` rises after edge E+4 with exactly 3 idle cycles in WAIT.
- Backpressure: push 2 transactions (0x01/0x02 then 0x03/0x04, delay 0) and hold `in_ready`=0 for 5 cycles. Required: `in_valid` held, data stable at 0x01/0x02, then two consecutive transfers once `in_ready`=1; `sent_count`=2.
- FIFO full: with `in_ready`=0, push 5 transactions. Required: the 5th is refused (`txn_ready`=0 after 4 pushes, counting the one loaded into DRIVE only after its pop). All accepted entries are delivered in order once ready.
- Wrap and reset: preload `sent_count` to 0xFFFF via 65535 transfers or a force, then complete one transfer. Required: `sent_count`=0. Then assert `rst` with 2 entries queued and `in_valid` high. Required: `in_valid`=0 immediately, `busy`=0, no transfers after release until a new push.
